// File: rtl/ucode_seq_ctl_if.sv
// Handshake/bus bundle between the R/E pipeline and the microcode sequencer.
// Latency: none (wires only).
// Backpressure: none here; the sequencer stalls the R-stage through ucode_busy.
//
// Pipeline -> sequencer:
//   ucode_in_r   R-stage op needs microcode (traps arrive here too)
//   rom_addr     next ROM address from ucode_add (rom_start or next_addr)
//   u_f_done     done field of the microword at rom_addr_e
//   iu_hold_e    pipeline hold, freezes the sequencer
//   iu_flush_e   kills any in-flight sequence
// Sequencer -> pipeline:
//   u_done_l     low = idle/done (ucode_add selects rom_start)
//   rom_addr_e   address of the executing microword
//   nxt_addr_1/2/3  rom_addr_e + 1/2/3, wrapping at 2**AW
//   ucode_busy   sequence active, R-stage must not issue
//   ucode_cnt    unheld cycles spent in the current/last sequence
//   ucode_timeout  one-cycle pulse on watchdog abort
interface ucode_seq_ctl_if #(
  parameter int AW = 9,
  parameter int CW = 7
);
  logic          ucode_in_r;
  logic [AW-1:0] rom_addr;
  logic          u_f_done;
  logic          iu_hold_e;
  logic          iu_flush_e;

  logic          u_done_l;
  logic [AW-1:0] rom_addr_e;
  logic [AW-1:0] nxt_addr_1;
  logic [AW-1:0] nxt_addr_2;
  logic [AW-1:0] nxt_addr_3;
  logic          ucode_busy;
  logic [CW-1:0] ucode_cnt;
  logic          ucode_timeout;

  // Pipeline / decode side.
  modport master (
    output ucode_in_r, rom_addr, u_f_done, iu_hold_e, iu_flush_e,
    input  u_done_l, rom_addr_e, nxt_addr_1, nxt_addr_2, nxt_addr_3,
           ucode_busy, ucode_cnt, ucode_timeout
  );

  // Sequencer side.
  modport slave (
    input  ucode_in_r, rom_addr, u_f_done, iu_hold_e, iu_flush_e,
    output u_done_l, rom_addr_e, nxt_addr_1, nxt_addr_2, nxt_addr_3,
           ucode_busy, ucode_cnt, ucode_timeout
  );
endinterface

// File: rtl/ucode_seq_ctl.sv
// Microcode ROM address sequencer: registers the executing address, runs IDLE/RUN/HOLD.
// Latency: start microword executes 1 cycle after R decode; nxt_addr_k are combinational.
// Backpressure: iu_hold_e freezes all state; ucode_busy stalls R-stage issue while active.
//
// Ports:
//   clk    core clock
//   reset  asynchronous active-high reset
//   bus    ucode_seq_ctl_if.slave (see the interface file for signal meanings)
// Parameters:
//   AW        ROM address width
//   CW        cycle/watchdog counter width
//   MAX_UCYC  unheld RUN cycles allowed before a forced abort (< 2**CW)
module ucode_seq_ctl #(
  parameter int AW       = 9,
  parameter int CW       = 7,
  parameter int MAX_UCYC = 100
) (
  input  logic             clk,
  input  logic             reset,
  ucode_seq_ctl_if.slave   bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};
  localparam logic [CW-1:0] WDOG_LIM = CW'(MAX_UCYC);

  logic [1:0]    state_q,   state_d;
  logic [AW-1:0] addr_q,    addr_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic          done_l_q,  done_l_d;
  logic          busy_q,    busy_d;
  logic          timeout_q, timeout_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    done_l_d  = done_l_q;
    busy_d    = busy_q;
    // Pulse: cleared every edge, including held ones.
    timeout_d = 1'b0;

    if (bus.iu_flush_e) begin
      // Flush beats hold; address and count are left for debug visibility.
      state_d  = ST_IDLE;
      done_l_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.ucode_in_r && !bus.iu_hold_e) begin
            state_d  = ST_RUN;
            addr_d   = bus.rom_addr;
            cnt_d    = {{(CW-1){1'b0}}, 1'b1};
            done_l_d = 1'b1;
            busy_d   = 1'b1;
          end
        end

        // HOLD behaves exactly like RUN once the hold drops, so the
        // first unheld edge already advances; no extra bubble.
        ST_RUN, ST_HOLD: begin
          if (bus.iu_hold_e) begin
            state_d = ST_HOLD;
          end else if (bus.u_f_done) begin
            state_d  = ST_IDLE;
            done_l_d = 1'b0;
            busy_d   = 1'b0;
          end else if (cnt_q == WDOG_LIM) begin
            state_d   = ST_IDLE;
            done_l_d  = 1'b0;
            busy_d    = 1'b0;
            timeout_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            addr_d  = bus.rom_addr;
            if (cnt_q != CNT_SAT) begin
              cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
          end
        end

        default: begin
          // Unreachable encoding: fall back to a safe idle.
          state_d  = ST_IDLE;
          done_l_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      done_l_q  <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      done_l_q  <= done_l_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.u_done_l      = done_l_q;
  assign bus.rom_addr_e    = addr_q;
  assign bus.ucode_busy    = busy_q;
  assign bus.ucode_cnt     = cnt_q;
  assign bus.ucode_timeout = timeout_q;

  // Lookahead addresses for ucode_add; natural AW-bit wrap.
  assign bus.nxt_addr_1 = addr_q + AW'(1);
  assign bus.nxt_addr_2 = addr_q + AW'(2);
  assign bus.nxt_addr_3 = addr_q + AW'(3);

endmodule
